phrase_streamer: RTL and testbench
==================================

PHRASE_STREAMER -- requirements
Module: phrase_streamer

Interface
REQ-001 The block SHALL have parameter APPEND_CR, default 1; when 1, 0x0D (CR) is sent after the last phrase character.
REQ-002 The block SHALL have parameter APPEND_LF, default 1; when 1, 0x0A (LF) is sent after the CR slot, or directly after the last character if APPEND_CR=0.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request to stream the phrase selected by phrase_idx.
REQ-007 phrase_idx  input  3  phrase select, sampled only on an accepted start.
REQ-008 tx_data  output  8  ASCII byte to the terminal/UART transmitter.
REQ-009 tx_valid  output  1  tx_data holds a byte for transfer.
REQ-010 tx_ready  input  1  downstream accepts a byte when high together with tx_valid.
REQ-011 busy  output  1  high from start acceptance until done.
REQ-012 done  output  1  single-cycle pulse when a phrase stream completes.
REQ-013 last_idx  output  3  index of the most recently completed phrase; fed back as in_num to the random phrase selector so the next pick differs.

Function
REQ-014 The phrase ROM SHALL be, by index 0-7: "HELLO WORLD"(11), "HOW YOU DOIN"(12), "HEY"(3), "SUP"(3), "gmorning"(8), "what is life"(12), "argggg"(6), "I need h20"(10), in exact ASCII case; spaces are 0x20.
REQ-015 The FSM SHALL have states IDLE, SEND, CR, LF, DONE.
REQ-016 In IDLE, start=1 SHALL latch phrase_idx, clear the character counter (4 bits) to 0 and move to SEND; busy is high from the next cycle.
REQ-017 start SHALL be ignored in every state except IDLE; phrase_idx changes after acceptance SHALL not affect the current stream.
REQ-018 In SEND, tx_valid SHALL be 1 and tx_data SHALL be ROM[latched idx][counter]; first byte valid the cycle after start acceptance (latency 1).
REQ-019 A transfer SHALL occur on a cycle with tx_valid=1 and tx_ready=1; exactly one byte per transfer.
REQ-020 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL hold stable (no retraction, no change).
REQ-021 On a transfer in SEND the counter SHALL increment; on a transfer of the last character (counter = length-1) the FSM SHALL go to CR if APPEND_CR, else LF if APPEND_LF, else DONE.
REQ-022 In CR, tx_data SHALL be 0x0D; on transfer go to LF if APPEND_LF, else DONE. In LF, tx_data SHALL be 0x0A; on transfer go to DONE.
REQ-023 Back-to-back transfers SHALL be supported: with tx_ready held 1, one byte per cycle, no bubbles between characters, CR and LF.
REQ-024 In DONE, done=1 and tx_valid=0 for exactly one cycle, last_idx SHALL update to the latched index, busy drops, and the FSM returns to IDLE; a start in the DONE cycle SHALL be ignored.
REQ-025 tx_valid SHALL be 0 in IDLE and DONE; tx_data SHALL be 0x00 when tx_valid=0.
REQ-026 busy SHALL be 1 in SEND, CR and LF, and 0 in IDLE and DONE.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, counter 0, tx_valid 0, tx_data 0x00, busy 0, done 0, last_idx 0.
REQ-028 Reset asserted mid-stream SHALL abandon the phrase; after release the block sits in IDLE and emits nothing until a new start.
REQ-029 Release of rst_n SHALL be usable at any time relative to clk; the first start is accepted on the first rising edge with rst_n=1.

Verification
REQ-030 Defaults, tx_ready=1, start pulse with phrase_idx=2 -> bytes 0x48,0x45,0x59,0x0D,0x0A on 5 consecutive cycles starting 1 cycle after start; done pulses the next cycle; last_idx=2.
REQ-031 phrase_idx=5, tx_ready toggled 1/0 every cycle -> "what is life"+CR+LF (14 bytes) in order; tx_data stable on every stalled cycle; done once.
REQ-032 Start with phrase_idx=3, then start=1 with phrase_idx=0 held throughout the stream -> only "SUP"+CR+LF emitted; second phrase starts only after IDLE is re-entered.
REQ-033 APPEND_CR=0, APPEND_LF=0, phrase_idx=1 -> exactly 12 bytes "HOW YOU DOIN", done pulse, no 0x0D/0x0A.
REQ-034 rst_n pulsed low after 4 bytes of phrase 0 -> tx_valid, busy, last_idx drop to 0 asynchronously; no further bytes until the next start.
REQ-035 All 8 indices streamed back-to-back with tx_ready=1 -> byte-exact match against REQ-014 strings; last_idx tracks each index.

Source files
------------

// File: rtl/phrase_streamer_if.sv
// Byte stream handshake from the phrase streamer to a UART/terminal transmitter.
interface phrase_streamer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/phrase_streamer.sv
// Streams one of eight fixed ASCII phrases, optionally terminated by CR/LF,
// over a valid/ready byte interface. All outputs are registered.
module phrase_streamer #(
    parameter bit APPEND_CR = 1'b1,
    parameter bit APPEND_LF = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            phrase_idx,
    phrase_streamer_if.master     tx,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            last_idx
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ROM_W  = 96;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_CR,
        ST_LF,
        ST_DONE
    } state_t;

    // Phrase text, left-aligned: character 0 sits in the top byte.
    function automatic logic [ROM_W-1:0] rom_row(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    rom_row = {"HELLO WORLD", 8'h00};
            3'd1:    rom_row = "HOW YOU DOIN";
            3'd2:    rom_row = {"HEY", 72'h0};
            3'd3:    rom_row = {"SUP", 72'h0};
            3'd4:    rom_row = {"gmorning", 32'h0};
            3'd5:    rom_row = "what is life";
            3'd6:    rom_row = {"argggg", 48'h0};
            default: rom_row = {"I need h20", 16'h0};
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] rom_len(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    rom_len = 4'd11;
            3'd1:    rom_len = 4'd12;
            3'd2:    rom_len = 4'd3;
            3'd3:    rom_len = 4'd3;
            3'd4:    rom_len = 4'd8;
            3'd5:    rom_len = 4'd12;
            3'd6:    rom_len = 4'd6;
            default: rom_len = 4'd10;
        endcase
    endfunction

    function automatic logic [BYTE_W-1:0] rom_byte(input logic [IDX_W-1:0] idx,
                                                   input logic [CNT_W-1:0] cnt);
        logic [ROM_W-1:0] row;
        row = rom_row(idx);
        if (cnt > 4'd11) begin
            rom_byte = 8'h00;
        end else begin
            rom_byte = row[(ROM_W-1) - BYTE_W*32'(cnt) -: BYTE_W];
        end
    endfunction

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [BYTE_W-1:0]  r_tx_data;
    logic               r_tx_valid;
    logic               r_busy;
    logic               r_done;
    logic [IDX_W-1:0]   r_last_idx;

    state_t             w_state_next;
    logic [IDX_W-1:0]   w_idx_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [BYTE_W-1:0]  w_tx_data_next;
    logic               w_tx_valid_next;
    logic               w_busy_next;
    logic               w_done_next;
    logic               w_xfer;
    logic               w_last_char;
    state_t             w_after_text;

    assign w_xfer       = r_tx_valid & tx.tx_ready;
    assign w_last_char  = (r_cnt == rom_len(r_idx) - 4'd1);
    assign w_after_text = APPEND_CR ? ST_CR : (APPEND_LF ? ST_LF : ST_DONE);

    // State, latched phrase index and character counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state: advance only on a completed transfer; start honoured in IDLE only.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_SEND;
                    w_idx_next   = phrase_idx;
                    w_cnt_next   = '0;
                end
            end
            ST_SEND: begin
                if (w_xfer) begin
                    w_cnt_next = r_cnt + 4'd1;
                    if (w_last_char) begin
                        w_state_next = w_after_text;
                    end
                end
            end
            ST_CR: begin
                if (w_xfer) begin
                    w_state_next = APPEND_LF ? ST_LF : ST_DONE;
                end
            end
            ST_LF: begin
                if (w_xfer) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        w_tx_data_next  = 8'h00;
        w_tx_valid_next = 1'b0;
        w_busy_next     = 1'b0;
        w_done_next     = 1'b0;
        case (w_state_next)
            ST_SEND: begin
                w_tx_valid_next = 1'b1;
                w_tx_data_next  = rom_byte(w_idx_next, w_cnt_next);
                w_busy_next     = 1'b1;
            end
            ST_CR: begin
                w_tx_valid_next = 1'b1;
                w_tx_data_next  = 8'h0D;
                w_busy_next     = 1'b1;
            end
            ST_LF: begin
                w_tx_valid_next = 1'b1;
                w_tx_data_next  = 8'h0A;
                w_busy_next     = 1'b1;
            end
            ST_DONE: w_done_next = 1'b1;
            default: ;
        endcase
    end

    // Output registers; last_idx captures the phrase as it completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_last_idx <= '0;
        end else begin
            r_tx_data  <= w_tx_data_next;
            r_tx_valid <= w_tx_valid_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            if (w_state_next == ST_DONE) begin
                r_last_idx <= r_idx;
            end
        end
    end

    assign tx.tx_data  = r_tx_data;
    assign tx.tx_valid = r_tx_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign last_idx    = r_last_idx;

endmodule

// File: tb/tb_phrase_streamer.sv
// Directed bench: default-parameter DUT (u_a) and a bare-text DUT (u_b).
module tb_phrase_streamer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a;
    logic       start_b;
    logic       ready;
    logic [2:0] pidx;
    logic       busy_a, done_a, busy_b, done_b;
    logic [2:0] last_a, last_b;
    logic       sel;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_done;
    logic [2:0] m_last;

    int checks   = 0;
    int failures = 0;

    string phrases [8] = '{"HELLO WORLD", "HOW YOU DOIN", "HEY", "SUP",
                           "gmorning", "what is life", "argggg", "I need h20"};

    always #5 clk = ~clk;

    phrase_streamer_if aif ();
    phrase_streamer_if bif ();

    assign aif.tx_ready = ready;
    assign bif.tx_ready = ready;

    phrase_streamer u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_a),
        .phrase_idx (pidx),
        .tx         (aif),
        .busy       (busy_a),
        .done       (done_a),
        .last_idx   (last_a)
    );

    phrase_streamer #(.APPEND_CR(1'b0), .APPEND_LF(1'b0)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .phrase_idx (pidx),
        .tx         (bif),
        .busy       (busy_b),
        .done       (done_b),
        .last_idx   (last_b)
    );

    assign m_data  = sel ? bif.tx_data  : aif.tx_data;
    assign m_valid = sel ? bif.tx_valid : aif.tx_valid;
    assign m_done  = sel ? done_b : done_a;
    assign m_last  = sel ? last_b : last_a;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic string with_crlf(input string s);
        return $sformatf("%s%c%c", s, 8'h0D, 8'h0A);
    endfunction

    // Collect transferred bytes until done, then compare against the expected string.
    task automatic collect(input string tag, input string exp, input bit toggle,
                           input int idx, input bit tail);
        logic [7:0] q [$];
        int         dones     = 0;
        int         stall_bad = 0;
        int         idle_bad  = 0;
        int         extra     = 0;
        bit         st_prev   = 1'b0;
        logic [7:0] held      = 8'h00;
        for (int c = 0; c < 200 && dones == 0; c++) begin
            ready = (toggle && c[0]) ? 1'b0 : 1'b1;
            if (st_prev && !(m_valid === 1'b1 && m_data === held)) stall_bad++;
            st_prev = m_valid && !ready;
            held    = m_data;
            if (m_valid && ready) q.push_back(m_data);
            if (!m_valid && m_data !== 8'h00) idle_bad++;
            if (m_done) begin
                dones++;
                check_val({tag, "_last_idx"}, 32'(m_last), 32'(idx));
            end
            tick();
        end
        ready = 1'b1;
        check_val({tag, "_done_cnt"}, 32'(dones), 32'd1);
        if (tail) begin
            for (int k = 0; k < 3; k++) begin
                if (m_done || m_valid) extra++;
                tick();
            end
            check_val({tag, "_quiet_after"}, 32'(extra), 32'd0);
        end
        check_val({tag, "_len"}, 32'(q.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len() && i < q.size(); i++) begin
            check_val($sformatf("%s_byte%0d", tag, i), 32'(q[i]), 32'(exp[i]));
        end
        check_val({tag, "_stall_hold"}, 32'(stall_bad), 32'd0);
        check_val({tag, "_idle_data"}, 32'(idle_bad), 32'd0);
    endtask

    task automatic stream(input string tag, input bit use_b, input int idx,
                          input bit toggle, input string exp);
        sel  = use_b;
        pidx = 3'(idx);
        if (use_b) start_b = 1'b1;
        else       start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        collect(tag, exp, toggle, idx, 1'b1);
    endtask

    logic [7:0] exp30 [5];
    int         cnt_bad;

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        ready   = 1'b1;
        pidx    = 3'd0;
        sel     = 1'b0;
        exp30   = '{8'h48, 8'h45, 8'h59, 8'h0D, 8'h0A};

        // Reset values
        #12;
        check_val("rst_valid", 32'(aif.tx_valid), 32'd0);
        check_val("rst_data", 32'(aif.tx_data), 32'd0);
        check_val("rst_busy", 32'(busy_a), 32'd0);
        check_val("rst_done", 32'(done_a), 32'd0);
        check_val("rst_last", 32'(last_a), 32'd0);

        // Phrase 2 back-to-back, exact cycle timing; first start right after release
        @(negedge clk);
        rst_n   = 1'b1;
        start_a = 1'b1;
        pidx    = 3'd2;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("p2_valid%0d", i), 32'(aif.tx_valid), 32'd1);
            check_val($sformatf("p2_data%0d", i), 32'(aif.tx_data), 32'(exp30[i]));
            check_val($sformatf("p2_busy%0d", i), 32'(busy_a), 32'd1);
            tick();
        end
        check_val("p2_done", 32'(done_a), 32'd1);
        check_val("p2_done_valid", 32'(aif.tx_valid), 32'd0);
        check_val("p2_done_data", 32'(aif.tx_data), 32'd0);
        check_val("p2_done_busy", 32'(busy_a), 32'd0);
        check_val("p2_last", 32'(last_a), 32'd2);
        tick();
        check_val("p2_done_pulse", 32'(done_a), 32'd0);

        // Phrase 5 with ready toggling every cycle
        stream("p5_stall", 1'b0, 5, 1'b1, with_crlf(phrases[5]));

        // Start held high with a different index during phrase 3
        sel     = 1'b0;
        start_a = 1'b1;
        pidx    = 3'd3;
        tick();
        pidx    = 3'd0;
        collect("p3_held", with_crlf("SUP"), 1'b0, 3, 1'b0);
        check_val("p3_idle_after", 32'(aif.tx_valid), 32'd0);
        tick();
        start_a = 1'b0;
        check_val("p3_next_valid", 32'(aif.tx_valid), 32'd1);
        check_val("p3_next_data", 32'(aif.tx_data), 32'h48);
        collect("p0_after", with_crlf(phrases[0]), 1'b0, 0, 1'b1);

        // No terminator variant
        stream("b_p1", 1'b1, 1, 1'b0, phrases[1]);

        // All phrases back-to-back
        for (int i = 0; i < 8; i++) begin
            stream($sformatf("all_p%0d", i), 1'b0, i, 1'b0, with_crlf(phrases[i]));
        end

        // Reset mid-stream after four bytes of phrase 0
        sel     = 1'b0;
        pidx    = 3'd0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        check_val("mid_pre_data", 32'(aif.tx_data), 32'h4F);
        check_val("mid_pre_last", 32'(last_a), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(aif.tx_valid), 32'd0);
        check_val("mid_rst_data", 32'(aif.tx_data), 32'd0);
        check_val("mid_rst_busy", 32'(busy_a), 32'd0);
        check_val("mid_rst_last", 32'(last_a), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        cnt_bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (aif.tx_valid || busy_a || done_a) cnt_bad++;
        end
        check_val("mid_quiet", 32'(cnt_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
